// File: rtl/cardinal_nic_pkg.sv
//------------------------------------------------------------------------------
// cardinal_nic_pkg : register map and packet layout shared by the NIC and router
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cardinal_nic_pkg;

  localparam logic [1:0] NIC_ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  localparam int PKT_WIDTH = 64;

  // Index in the router's MSB-first [0:63] numbering; bit 0 is the packet MSB.
  localparam int VC_BIT = 0;

  // Packed MSB-first, so the first member is bit 0 of the router's bus.
  typedef struct packed {
    logic        vc;
    logic        dir_x;
    logic        dir_y;
    logic [4:0]  rsvd_hdr;
    logic [7:0]  hop_x;
    logic [7:0]  hop_y;
    logic [7:0]  rsvd_ctl;
    logic [31:0] payload;
  } nic_pkt_t;

endpackage

`default_nettype wire

// File: rtl/nic_channel_buf.sv
//------------------------------------------------------------------------------
// nic_channel_buf : one-entry packet buffer with full flag, load and clear
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nic_channel_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // A load is only taken into an empty slot; the held data survives a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (load && !r_full) begin
      r_data <= load_data;
      r_full <= 1'b1;
    end else if (clear) begin
      r_full <= 1'b0;
    end
  end

  assign data = r_data;
  assign full = r_full;

endmodule

`default_nettype wire

// File: rtl/cardinal_nic.sv
//------------------------------------------------------------------------------
// cardinal_nic : memory-mapped NIC between processor data port and mesh router
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = cardinal_nic_pkg::VC_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  import cardinal_nic_pkg::*;

  // Router bit k (MSB-first numbering) is physical bit DATA_WIDTH-1-k here.
  localparam int c_vc_pos = DATA_WIDTH - 1 - VC_BIT;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_in_clear;
  logic                  w_out_load;
  logic                  w_in_full;
  logic                  w_out_full;
  logic                  w_net_so;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [DATA_WIDTH-1:0] r_d_out;

  assign w_rd       = nicEn & ~nicWrEn;
  assign w_wr       = nicEn &  nicWrEn;
  assign w_in_clear = w_rd && (addr == NIC_ADDR_IN_DATA);
  assign w_out_load = w_wr && (addr == NIC_ADDR_OUT_DATA);

  nic_channel_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (net_si),
    .clear     (w_in_clear),
    .load_data (net_di),
    .data      (w_in_data),
    .full      (w_in_full)
  );

  nic_channel_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (w_out_load),
    .clear     (w_net_so),
    .load_data (d_in),
    .data      (w_out_data),
    .full      (w_out_full)
  );

  assign w_net_so = w_out_full & net_ro & (w_out_data[c_vc_pos] == net_polarity);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      case (addr)
        NIC_ADDR_IN_DATA:  r_d_out <= w_in_data;
        NIC_ADDR_IN_STAT:  r_d_out <= {{(DATA_WIDTH-1){1'b0}}, w_in_full};
        NIC_ADDR_OUT_DATA: r_d_out <= w_out_data;
        NIC_ADDR_OUT_STAT: r_d_out <= {{(DATA_WIDTH-1){1'b0}}, w_out_full};
      endcase
    end
  end

  assign d_out  = r_d_out;
  assign net_ri = ~w_in_full;
  assign net_so = w_net_so;
  assign net_do = w_out_data;

endmodule

`default_nettype wire

// File: tb/tb_cardinal_nic.sv
//------------------------------------------------------------------------------
// tb_cardinal_nic : directed stimulus against a cycle model of cardinal_nic
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cardinal_nic;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   addr;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         nicEn;
  logic         nicWrEn;
  logic         net_si;
  logic         net_ri;
  logic [W-1:0] net_di;
  logic         net_so;
  logic         net_ro;
  logic [W-1:0] net_do;
  logic         net_polarity;

  always #5 clk = ~clk;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: two single slots with flags, and the last read result.
  logic         m_valid = 1'b0;
  logic         m_in_full, m_out_full;
  logic [W-1:0] m_in_buf, m_out_buf, m_dout;

  // The VC tag is the packet's first (most significant) bit.
  function automatic logic m_send();
    return m_out_full && net_ro && (m_out_buf[W-1] == net_polarity);
  endfunction

  always @(posedge clk) begin : model
    logic send, rd, wr, capture;
    if (reset) begin
      m_in_full = 1'b0; m_out_full = 1'b0;
      m_in_buf = '0; m_out_buf = '0; m_dout = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      send    = m_send();
      rd      = nicEn && !nicWrEn;
      wr      = nicEn && nicWrEn && (addr == 2'd2);
      capture = net_si && !m_in_full;
      if (rd) begin
        case (addr)
          2'd0: m_dout = m_in_buf;
          2'd1: m_dout = {{(W-1){1'b0}}, m_in_full};
          2'd2: m_dout = m_out_buf;
          default: m_dout = {{(W-1){1'b0}}, m_out_full};
        endcase
      end
      if (capture) begin
        m_in_buf = net_di; m_in_full = 1'b1;
      end else if (rd && addr == 2'd0) begin
        m_in_full = 1'b0;
      end
      if (send) m_out_full = 1'b0;
      else if (wr && !m_out_full) begin
        m_out_buf = d_in; m_out_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_net_ri", net_ri, !m_in_full);
      check("cyc_net_so", net_so, m_send());
      check("cyc_net_do", net_do, m_out_buf);
      check("cyc_d_out", d_out, m_dout);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
    step();
    nicEn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 2'd0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_net_ri", net_ri, 1'b1);
    check("rst_net_so", net_so, 1'b0);
    check("rst_d_out", d_out, '0);
    rd(2'd1); check("rst_in_stat", d_out, '0);
    rd(2'd3); check("rst_out_stat", d_out, '0);

    // Send gated by polarity; a write on the send edge is dropped.
    net_ro = 1'b1; net_polarity = 1'b1;
    wr(2'd2, 64'h0000_0000_0000_00AA);
    check("pol_mismatch_so", net_so, 1'b0);
    step();
    check("pol_mismatch_so2", net_so, 1'b0);
    net_polarity = 1'b0;
    #1;
    check("pol_match_so", net_so, 1'b1);
    check("pol_match_do", net_do, 64'h0000_0000_0000_00AA);
    wr(2'd2, 64'h0000_0000_0000_0055);
    check("send_one_cycle", net_so, 1'b0);
    rd(2'd3); check("sent_out_stat", d_out, '0);
    rd(2'd2); check("write_on_send_dropped", d_out, 64'h0000_0000_0000_00AA);
    wr(2'd3, 64'h1234);
    wr(2'd0, 64'h77);
    rd(2'd3); check("ignored_wr_out_stat", d_out, '0);
    rd(2'd1); check("ignored_wr_in_stat", d_out, '0);

    // Second write while full is dropped.
    net_ro = 1'b0;
    wr(2'd2, 64'h8000_0000_0000_0001);
    wr(2'd2, 64'h0000_0000_0000_0002);
    rd(2'd2); check("full_wr_dropped", d_out, 64'h8000_0000_0000_0001);
    rd(2'd3); check("out_stat_full", d_out, 64'h1);

    // Input capture and read-back.
    net_di = 64'hDEAD_BEEF_0000_0001; net_si = 1'b1;
    step();
    net_si = 1'b0;
    check("cap_net_ri", net_ri, 1'b0);
    rd(2'd1); check("cap_in_stat", d_out, 64'h1);
    rd(2'd0); check("cap_in_data", d_out, 64'hDEAD_BEEF_0000_0001);
    check("read_net_ri", net_ri, 1'b1);

    // net_si held across the read edge: capture only on the following edge.
    net_di = 64'hCAFE_0000_0000_0002; net_si = 1'b1;
    step();
    check("cap2_net_ri", net_ri, 1'b0);
    net_di = 64'h1234_5678_0000_0003;
    rd(2'd0);
    check("overlap_old_pkt", d_out, 64'hCAFE_0000_0000_0002);
    check("overlap_ri_free", net_ri, 1'b1);
    step();
    net_si = 1'b0;
    check("overlap_captured", net_ri, 1'b0);
    rd(2'd1); check("overlap_in_stat", d_out, 64'h1);
    rd(2'd0); check("overlap_new_pkt", d_out, 64'h1234_5678_0000_0003);

    // Both buffers full, reset drops them even with a send enabled.
    net_di = 64'h0F0F_0F0F_0F0F_0F0F; net_si = 1'b1;
    step();
    net_si = 1'b0;
    reset = 1'b1; net_ro = 1'b1; net_polarity = 1'b1;
    #1;
    check("pre_rst_so", net_so, 1'b1);
    step();
    reset = 1'b0;
    check("mid_rst_so", net_so, 1'b0);
    check("mid_rst_ri", net_ri, 1'b1);
    check("mid_rst_d_out", d_out, '0);
    rd(2'd1); check("mid_rst_in_stat", d_out, '0);
    rd(2'd3); check("mid_rst_out_stat", d_out, '0);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Memory-mapped network interface between the four-stage processor's data-memory port and the local port of a mesh router.
- The processor writes outgoing 64-bit packets into a one-entry output channel buffer. The block injects each packet into the router when the router is ready and the virtual-channel polarity matches.
- Packets ejected by the router land in a one-entry input channel buffer, which the processor polls and reads.
- Sits alongside dmem on the processor's data side; the address decode selects it via nicEn.

Parameters:
DATA_WIDTH, 64, packet and processor data width; bus bit order [0:DATA_WIDTH-1].
VC_BIT, 0, packet bit index carrying the virtual-channel tag compared against polarity.

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
addr  input  2  register select: 00 input-buffer data, 01 input status, 10 output-buffer data, 11 output status
d_in  input  DATA_WIDTH  processor write data
d_out  output  DATA_WIDTH  processor read data (registered)
nicEn  input  1  access enable from processor
nicWrEn  input  1  1 = write, 0 = read (valid when nicEn=1)
net_si  input  1  router has packet for this node
net_ri  output  1  NIC can accept a packet (input buffer empty)
net_di  input  DATA_WIDTH  packet from router
net_so  output  1  NIC presents packet to router this cycle
net_ro  input  1  router can accept a packet
net_do  output  DATA_WIDTH  packet to router
net_polarity  input  1  router's current VC phase (0 even, 1 odd)

Behaviour:
Reset values:
- On posedge with reset=1: in_full=0, out_full=0, in_buf=0, out_buf=0, d_out=0.
- Consequently net_ri=1 and net_so=0 on the first cycle after reset.
- Reset mid-transfer drops both buffered packets; no partial send.

Input channel:
- net_ri = ~in_full (combinational).
- On posedge with net_si=1 and in_full=0: in_buf<=net_di, in_full<=1.
- net_si while in_full=1 is a router protocol violation; in_buf is unchanged.

Output channel:
- Processor write (nicEn=1, nicWrEn=1, addr=10) with out_full=0: out_buf<=d_in, out_full<=1.
- The same write with out_full=1 is silently dropped. Software polls addr 11 first.
- Writes to 00, 01 and 11 are ignored.
- net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity) (combinational). net_do = out_buf always.
- On posedge with net_so=1: out_full<=0. The router samples net_do on the same edge.

Processor read (nicEn=1, nicWrEn=0), 1-cycle latency, d_out loaded on posedge:
- 00: d_out<=in_buf; in_full<=0 on the same edge.
- 01: d_out<={zeros, in_full} (flag in LSB, bit DATA_WIDTH-1).
- 10: d_out<=out_buf, no side effect.
- 11: d_out<={zeros, out_full}.
- When nicEn=0, d_out holds its previous value.

Simultaneous events:
- Read of 00 and net_si on the same edge: net_ri was 0, so no capture. The new packet is accepted the next cycle once net_ri=1.
- Write to 10 on the same edge as a send completes: the write sees out_full=1 and is dropped. Software must re-poll.
- Input and output channels are fully independent; a capture and a send may occur on the same edge.

Decomposition:
- Shared package holds:
  - address constants NIC_ADDR_IN_DATA=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_DATA=2'b10, NIC_ADDR_OUT_STAT=2'b11;
  - VC_BIT;
  - the packet field layout (VC, direction, hop counts, payload) that cardinal_nic shares with the router.
- One natural sub-module: nic_channel_buf, a one-entry buffer with full flag, load and clear. Instantiate it twice (input and output) inside cardinal_nic.

Test Plan:
- Reset for 3 cycles, then release -> net_ri=1, net_so=0, d_out=0; reads of addr 01 and 11 return 0.
- Write 64'h0000_0000_0000_00AA (VC bit 0) to addr 10 with net_ro=1, net_polarity=1 -> net_so stays 0. Flip polarity to 0 -> net_so=1 for exactly one cycle with net_do=64'h...00AA. Addr 11 then reads 0.
- Write 64'h8000_0000_0000_0001 to addr 10, then a second write 64'h...0002 while full, with net_ro=0 -> addr 10 reads 64'h8000_0000_0000_0001. The second write is dropped.
- Drive net_si=1 with net_di=64'hDEAD_BEEF_0000_0001 -> net_ri falls next cycle and addr 01 reads 1. Read addr 00 -> d_out=64'hDEAD_BEEF_0000_0001 one cycle later, and net_ri=1 again.
- Hold net_si=1 with a new packet during the addr 00 read edge -> old packet returned, new packet captured the following edge, and addr 01 reads 1 afterwards.
- Fill both buffers, assert reset for 1 cycle -> both status reads return 0, net_so=0, net_ri=1.
